ring_queue: RTL and testbench
=============================

# ring_queue

Parametrised circular FIFO, successor to the fixed 8-bit single-mode queue. Buffers WIDTH-bit words in a DEPTH-entry register array between a producer (insert) and consumer (read). Build-time selection between overwrite-oldest and drop-newest policies on full. Exports occupancy and error pulses for the control/status path.

## Interface
- WIDTH, 8, data word width (>=1)
- DEPTH, 16, entry count (>=2; need not be a power of two)
- OVERWRITE, 1, 1 = insert on full overwrites oldest entry; 0 = insert on full is discarded
- CW, $clog2(DEPTH+1), derived count width (localparam, not overridable)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of queue contents
- insert  in  1  write request, data_i sampled this edge
- read  in  1  read request
- data_i  in  WIDTH  write data
- valid_o  out  1  one-cycle pulse, data_o carries a popped word
- data_o  out  WIDTH  popped word; holds last value when valid_o=0
- count_o  out  CW  current occupancy 0..DEPTH
- empty_o  out  1  count_o==0
- full_o  out  1  count_o==DEPTH
- dropped_o  out  1  one-cycle pulse: oldest entry lost (OVERWRITE=1) or incoming word discarded (OVERWRITE=0)
- underflow_o  out  1  one-cycle pulse: read while empty

## Operation
- State: wr_ptr, rd_ptr (0..DEPTH-1, wrap DEPTH-1 -> 0 explicitly, no power-of-two masking), count (CW bits), mem[DEPTH].
- Priority per edge: rst > flush > insert/read.
- flush: wr_ptr=rd_ptr=count=0; same-cycle insert/read ignored; valid_o, dropped_o, underflow_o = 0 next cycle; mem not cleared.
- insert, not full: mem[wr_ptr]<=data_i, wr_ptr++, count++.
- insert, full, no read: OVERWRITE=1 -> write at wr_ptr, wr_ptr++, rd_ptr++, count stays DEPTH, dropped_o=1. OVERWRITE=0 -> no write, no pointer change, dropped_o=1.
- read, not empty: data_o<=mem[rd_ptr], valid_o=1, rd_ptr++, count--.
- read, empty: no state change, valid_o=0, underflow_o=1.
- insert+read, 0<count<DEPTH: both performed, count unchanged.
- insert+read, empty: insert performed, read ignored (no bypass), underflow_o=1, count becomes 1.
- insert+read, full (either policy): both performed, count stays DEPTH, dropped_o=0. wr_ptr==rd_ptr here: read returns pre-write (old) contents.
- empty_o/full_o/count_o are combinational decodes of registered count.

## Timing
- Reset values: valid_o=0, data_o=0, count_o=0, empty_o=1, full_o=0, dropped_o=0, underflow_o=0, pointers 0.
- Reset asserted mid-operation clears immediately (async); pending valid_o pulse is cancelled.
- Write latency: word inserted at edge N is readable by a read request at edge N+1.
- Read latency: read sampled at edge N -> data_o/valid_o updated after edge N, visible for cycle N..N+1.
- Back-to-back reads each cycle yield one valid_o per cycle, no bubbles.
- count_o/full_o/empty_o reflect edge N results during cycle after N.
- Throughput: one insert and one read per cycle sustained.

## Structure
- Shared package (queue_pkg): policy constants POLICY_DROP=0, POLICY_OVERWRITE=1; pointer-increment-with-wrap function.
- Sub-module ring_queue_mem: DEPTH x WIDTH register array, one write port, one registered read port with read-before-write on address collision. Control (pointers, count, flags) stays in ring_queue.
- No SRAM macro; flop array only.

## Test plan
- Reset, then insert=0 with data_i=0xEC for 1 cycle -> count_o=0, empty_o=1, valid_o never asserted.
- WIDTH=8, DEPTH=4: insert 0x01,0x02,0x03 then 3 reads -> valid_o pulses with data_o 0x01,0x02,0x03 in order; count 3->0; 4th read -> underflow_o=1, data_o holds 0x03.
- OVERWRITE=1, DEPTH=4: insert 0..9 then 4 reads -> dropped_o pulses 6 times, reads return 6,7,8,9, full_o=1 after 4th insert.
- OVERWRITE=0, DEPTH=4: insert 0..9 then 4 reads -> dropped_o pulses 6 times, reads return 0,1,2,3.
- Full queue, insert 0xAA + read same cycle (both policies) -> data_o=oldest word, count stays 4, dropped_o=0; empty queue insert+read -> underflow_o=1, count=1.
- Count=3, flush with insert+read asserted -> count_o=0, no valid_o; rst asserted mid read-stream -> outputs return to reset values same cycle.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared policy constants and pointer helper for the ring_queue family.
package queue_pkg;

  localparam bit POLICY_DROP      = 1'b0;
  localparam bit POLICY_OVERWRITE = 1'b1;

  // Advance a ring pointer, wrapping explicitly at limit-1 so any depth works.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] limit);
    return (ptr == limit - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ring_queue_mem.sv
// DEPTH x WIDTH flop array: one write port, one registered read port
// that returns the pre-write contents when both ports hit the same entry.
module ring_queue_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register holds its last word while no read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ring_queue.sv
// Parametrised circular FIFO with build-time overwrite-oldest / drop-newest
// policy on full; pointers, occupancy and status pulses live here.
module ring_queue
  import queue_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter bit          OVERWRITE = POLICY_OVERWRITE,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             insert,
  input  logic             read,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             dropped_o,
  output logic             underflow_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          valid_d, valid_q;
  logic          dropped_d, dropped_q;
  logic          underflow_d, underflow_q;
  logic          mem_we, mem_re;
  logic          is_empty, is_full;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return PW'(ptr_inc(32'(p), 32'(DEPTH)));
  endfunction

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // Read is resolved on pre-edge state first; an insert on full with a
  // concurrent read frees a slot, so it never counts as a drop.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    valid_d     = 1'b0;
    dropped_d   = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (read) begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          mem_re   = 1'b1;
          valid_d  = 1'b1;
          rd_ptr_d = ptr_next(rd_ptr_q);
        end
      end
      if (insert) begin
        if (!is_full || read) begin
          mem_we   = 1'b1;
          wr_ptr_d = ptr_next(wr_ptr_q);
        end else if (OVERWRITE) begin
          mem_we    = 1'b1;
          wr_ptr_d  = ptr_next(wr_ptr_q);
          rd_ptr_d  = ptr_next(rd_ptr_q);
          dropped_d = 1'b1;
        end else begin
          dropped_d = 1'b1;
        end
      end
      if (mem_we && !mem_re && !is_full) begin
        count_d = count_q + CW'(1);
      end else if (mem_re && !mem_we) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      dropped_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      dropped_q   <= dropped_d;
      underflow_q <= underflow_d;
    end
  end

  ring_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (data_i),
    .re    (mem_re),
    .raddr (rd_ptr_q),
    .rdata (data_o)
  );

  assign valid_o     = valid_q;
  assign dropped_o   = dropped_q;
  assign underflow_o = underflow_q;
  assign count_o     = count_q;
  assign empty_o     = is_empty;
  assign full_o      = is_full;

endmodule

// File: tb/tb_ring_queue.sv
// Self-checking bench: overwrite and drop variants (DEPTH=4) driven in
// parallel and compared against a queue-based reference model.
module tb_ring_queue;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D + 1);

  typedef logic [W-1:0] q_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0, insert = 1'b0, read = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          valid[2], empty[2], full[2], dropped[2], uflow[2];
  logic [W-1:0]  dout[2];
  logic [CW-1:0] cnt[2];

  int n_cmp = 0;
  int n_bad = 0;

  q_t           q0, q1;
  bit           e_valid[2], e_drop[2], e_uf[2];
  logic [W-1:0] e_data[2];
  int           e_cnt[2];

  always #5 clk = ~clk;

  ring_queue #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b1)) u_ow (
    .clk(clk), .rst(rst), .flush(flush), .insert(insert), .read(read), .data_i(data_i),
    .valid_o(valid[0]), .data_o(dout[0]), .count_o(cnt[0]), .empty_o(empty[0]),
    .full_o(full[0]), .dropped_o(dropped[0]), .underflow_o(uflow[0]));

  ring_queue #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b0)) u_dr (
    .clk(clk), .rst(rst), .flush(flush), .insert(insert), .read(read), .data_i(data_i),
    .valid_o(valid[1]), .data_o(dout[1]), .count_o(cnt[1]), .empty_o(empty[1]),
    .full_o(full[1]), .dropped_o(dropped[1]), .underflow_o(uflow[1]));

  // Reference behaviour: a bounded queue; read sees the pre-edge contents.
  task automatic model_step(inout q_t q, input bit ow, output bit v, inout logic [W-1:0] d,
                            output bit dr, output bit uf, output int c);
    int pre;
    v = 0; dr = 0; uf = 0;
    if (flush) begin
      q.delete();
    end else begin
      pre = q.size();
      if (read) begin
        if (pre > 0) begin d = q.pop_front(); v = 1; end
        else uf = 1;
      end
      if (insert) begin
        if (q.size() < D) q.push_back(data_i);
        else begin
          dr = 1;
          if (ow) begin void'(q.pop_front()); q.push_back(data_i); end
        end
      end
    end
    c = q.size();
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++) begin
      e_valid[k] = 0; e_drop[k] = 0; e_uf[k] = 0; e_data[k] = '0; e_cnt[k] = 0;
    end
  endtask

  task automatic step(input bit f, input bit ins, input bit rd, input logic [W-1:0] d);
    flush = f; insert = ins; read = rd; data_i = d;
    @(posedge clk);
    model_step(q0, 1'b1, e_valid[0], e_data[0], e_drop[0], e_uf[0], e_cnt[0]);
    model_step(q1, 1'b0, e_valid[1], e_data[1], e_drop[1], e_uf[1], e_cnt[1]);
    #1;
    flush = 0; insert = 0; read = 0;
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; insert = 0; read = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    step(0, 0, 0, 8'hEC);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (cnt[k] !== '0) begin n_bad++; $display("FAIL reset_count dut%0d got %0d want 0", k, cnt[k]); end
      n_cmp++; if (empty[k] !== 1'b1) begin n_bad++; $display("FAIL reset_empty dut%0d got %b want 1", k, empty[k]); end
      n_cmp++; if (valid[k] !== 1'b0 || full[k] !== 1'b0 || dropped[k] !== 1'b0 || uflow[k] !== 1'b0 || dout[k] !== '0)
        begin n_bad++; $display("FAIL reset_flags dut%0d v=%b f=%b d=%b u=%b data=%h want all 0", k, valid[k], full[k], dropped[k], uflow[k], dout[k]); end
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] want;
    do_reset();
    for (int i = 1; i <= 3; i++) step(0, 1, 0, W'(i));
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (cnt[k] !== CW'(3)) begin n_bad++; $display("FAIL basic_count3 dut%0d got %0d want 3", k, cnt[k]); end
    end
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 1, '0);
      want = W'(i);
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (valid[k] !== 1'b1 || dout[k] !== want || cnt[k] !== CW'(3 - i))
          begin n_bad++; $display("FAIL basic_read%0d dut%0d got v=%b data=%h cnt=%0d want v=1 data=%h cnt=%0d", i, k, valid[k], dout[k], cnt[k], want, 3 - i); end
      end
    end
    step(0, 0, 1, '0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (uflow[k] !== 1'b1 || valid[k] !== 1'b0 || dout[k] !== 8'h03)
        begin n_bad++; $display("FAIL basic_underflow dut%0d got u=%b v=%b data=%h want u=1 v=0 data=03", k, uflow[k], valid[k], dout[k]); end
    end
  endtask

  task automatic test_policy();
    int drops[2];
    logic [W-1:0] want;
    do_reset();
    drops[0] = 0; drops[1] = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, W'(i));
      for (int k = 0; k < 2; k++) if (dropped[k] === 1'b1) drops[k]++;
      if (i == 3) for (int k = 0; k < 2; k++) begin
        n_cmp++; if (full[k] !== 1'b1) begin n_bad++; $display("FAIL policy_full dut%0d got %b want 1", k, full[k]); end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (drops[k] != 6) begin n_bad++; $display("FAIL policy_drops dut%0d got %0d want 6", k, drops[k]); end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, '0);
      for (int k = 0; k < 2; k++) begin
        want = (k == 0) ? W'(6 + i) : W'(i);
        n_cmp++; if (valid[k] !== 1'b1 || dout[k] !== want)
          begin n_bad++; $display("FAIL policy_read%0d dut%0d got v=%b data=%h want v=1 data=%h", i, k, valid[k], dout[k], want); end
      end
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 0, W'(8'h10 + i));
    step(0, 1, 1, 8'hAA);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (dout[k] !== 8'h10 || valid[k] !== 1'b1 || cnt[k] !== CW'(4) || dropped[k] !== 1'b0)
        begin n_bad++; $display("FAIL full_rw dut%0d got data=%h v=%b cnt=%0d drop=%b want 10 1 4 0", k, dout[k], valid[k], cnt[k], dropped[k]); end
    end
    for (int i = 0; i < 4; i++) step(0, 0, 1, '0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (dout[k] !== 8'hAA) begin n_bad++; $display("FAIL full_rw_tail dut%0d got %h want aa", k, dout[k]); end
    end
    step(0, 1, 1, 8'h55);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (uflow[k] !== 1'b1 || cnt[k] !== CW'(1) || valid[k] !== 1'b0)
        begin n_bad++; $display("FAIL empty_rw dut%0d got u=%b cnt=%0d v=%b want 1 1 0", k, uflow[k], cnt[k], valid[k]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, W'(8'h30 + i));
    step(1, 1, 1, 8'h77);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (cnt[k] !== '0 || valid[k] !== 1'b0 || empty[k] !== 1'b1 || uflow[k] !== 1'b0)
        begin n_bad++; $display("FAIL flush dut%0d got cnt=%0d v=%b e=%b u=%b want 0 0 1 0", k, cnt[k], valid[k], empty[k], uflow[k]); end
    end
    step(0, 0, 1, '0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (uflow[k] !== 1'b1 || valid[k] !== 1'b0)
        begin n_bad++; $display("FAIL flush_after dut%0d got u=%b v=%b want 1 0", k, uflow[k], valid[k]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, W'($urandom));
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (valid[k] !== e_valid[k] || dout[k] !== e_data[k] || cnt[k] !== CW'(e_cnt[k]) ||
            empty[k] !== (e_cnt[k] == 0) || full[k] !== (e_cnt[k] == D) ||
            dropped[k] !== e_drop[k] || uflow[k] !== e_uf[k]) begin
          n_bad++;
          $display("FAIL random cyc%0d dut%0d got v=%b d=%h c=%0d e=%b f=%b dr=%b u=%b want v=%b d=%h c=%0d dr=%b u=%b",
                   n, k, valid[k], dout[k], cnt[k], empty[k], full[k], dropped[k], uflow[k],
                   e_valid[k], e_data[k], e_cnt[k], e_drop[k], e_uf[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, W'(8'hC0 + i));
    step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (valid[k] !== 1'b1 || dout[k] !== 8'hC1)
        begin n_bad++; $display("FAIL mid_pre dut%0d got v=%b d=%h want 1 c1", k, valid[k], dout[k]); end
    end
    #2 rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (valid[k] !== 1'b0 || dout[k] !== '0 || cnt[k] !== '0 || empty[k] !== 1'b1 || full[k] !== 1'b0)
        begin n_bad++; $display("FAIL mid_reset dut%0d got v=%b d=%h c=%0d e=%b f=%b want 0 00 0 1 0", k, valid[k], dout[k], cnt[k], empty[k], full[k]); end
    end
    #1 rst = 0;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_policy();
    test_full_rw();
    test_flush();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
